// File: rtl/code_patch_pkg.sv
// Shared definitions for the code patch unit: register word indices, CTRL bit
// layout, hit counter width and the fetch mode decode.
package code_patch_pkg;

    localparam int unsigned REG_CTRL      = 0;
    localparam int unsigned REG_STATUS    = 1;
    localparam int unsigned REG_SLOT_BASE = 2;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_PG_BIT   = 1;
    localparam int unsigned CTRL_SLOT_LSB = 2;

    localparam int unsigned HIT_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_OFF,
        MODE_PATCH,
        MODE_PATTERN
    } fetch_mode_e;

    function automatic fetch_mode_e decode_mode(input logic en, input logic pg);
        if (!en) begin
            return MODE_OFF;
        end
        return pg ? MODE_PATTERN : MODE_PATCH;
    endfunction

endpackage

// File: rtl/code_patch_regs.sv
// Wishbone register file for the code patch unit: address decode, registered
// acknowledge, CTRL and patch slot storage, STATUS read-clear strobe.
module code_patch_regs
    import code_patch_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 14,
    parameter int NUM_REGS   = 4,
    parameter int BUS_WIDTH  = 14
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cyc,
    input  logic                                  stb,
    input  logic                                  we,
    input  logic [ADDR_WIDTH-1:0]                 adr,
    input  logic [BUS_WIDTH-1:0]                  wdata,
    output logic [BUS_WIDTH-1:0]                  rdata,
    output logic                                  ack,
    input  logic [HIT_CNT_WIDTH-1:0]              hit_cnt,
    output logic [CTRL_SLOT_LSB+NUM_REGS-1:0]     ctrl,
    output logic [NUM_REGS-1:0][ADDR_WIDTH-1:0]   slot_addr,
    output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   slot_data,
    output logic                                  status_clr,
    output logic                                  mode_flip
);

    localparam int CTRL_W = int'(CTRL_SLOT_LSB) + NUM_REGS;
    localparam int WIDE_W = BUS_WIDTH + CTRL_W + ADDR_WIDTH + DATA_WIDTH + int'(HIT_CNT_WIDTH);

    logic                armed;
    logic                access;
    logic                commit;
    logic                rd_done;
    logic                sel_ctrl;
    logic                sel_status;
    logic [NUM_REGS-1:0] sel_addr;
    logic [NUM_REGS-1:0] sel_data;
    logic [WIDE_W-1:0]   wdata_ext;
    logic [WIDE_W-1:0]   rdata_ext;
    logic                unused_wdata;
    logic                unused_rdata;

    assign access    = cyc & stb;
    assign commit    = ack & access & we;
    assign rd_done   = ack & access & ~we;
    assign wdata_ext = WIDE_W'(wdata);

    assign unused_wdata = ^wdata_ext;
    assign unused_rdata = ^rdata_ext;

    always_comb begin
        sel_ctrl   = (adr == ADDR_WIDTH'(REG_CTRL));
        sel_status = (adr == ADDR_WIDTH'(REG_STATUS));
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            sel_addr[k] = (adr == ADDR_WIDTH'(REG_SLOT_BASE + 2 * k));
            sel_data[k] = (adr == ADDR_WIDTH'(REG_SLOT_BASE + 2 * k + 1));
        end
    end

    // armed holds off the very first ack after reset by one strobed edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
            ack   <= 1'b0;
        end else begin
            armed <= armed | access;
            ack   <= access & ~ack & armed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl      <= '0;
            slot_addr <= '0;
            slot_data <= '0;
        end else if (commit) begin
            if (sel_ctrl) begin
                ctrl <= wdata_ext[CTRL_W-1:0];
            end
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (sel_addr[k]) begin
                    slot_addr[k] <= wdata_ext[ADDR_WIDTH-1:0];
                end
                if (sel_data[k]) begin
                    slot_data[k] <= wdata_ext[DATA_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        rdata_ext = '0;
        if (sel_ctrl) begin
            rdata_ext = WIDE_W'(ctrl);
        end
        if (sel_status) begin
            rdata_ext = WIDE_W'(hit_cnt);
        end
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (sel_addr[k]) begin
                rdata_ext = WIDE_W'(slot_addr[k]);
            end
            if (sel_data[k]) begin
                rdata_ext = WIDE_W'(slot_data[k]);
            end
        end
    end

    assign rdata      = ack ? rdata_ext[BUS_WIDTH-1:0] : '0;
    assign status_clr = rd_done & sel_status;
    assign mode_flip  = commit & sel_ctrl & (wdata_ext[CTRL_PG_BIT] != ctrl[CTRL_PG_BIT]);

endmodule

// File: rtl/code_patch_unit.sv
// Code patch unit: substitutes fetch data from programmable slots (patch mode)
// or streams enabled slot data round-robin (pattern mode), counting hits.
module code_patch_unit
    import code_patch_pkg::*;
#(
    parameter int ADDR_WIDTH          = 12,
    parameter int DATA_WIDTH          = 14,
    parameter int NUM_REGS            = 4,
    parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           wb_si_cyc_i,
    input  logic                           wb_si_stb_i,
    input  logic                           wb_si_we_i,
    input  logic [ADDR_WIDTH-1:0]          wb_si_adr_i,
    input  logic [SUB_REGS_DATA_WIDTH-1:0] wb_si_dat_i,
    output logic [SUB_REGS_DATA_WIDTH-1:0] wb_si_dat_o,
    output logic                           wb_si_ack_o,
    input  logic                           fetch_valid_i,
    input  logic [ADDR_WIDTH-1:0]          fetch_addr_i,
    output logic                           patch_hit_o,
    output logic [DATA_WIDTH-1:0]          patch_data_o,
    output logic                           pg_valid_o,
    output logic                           nopg_o,
    output logic [15:0]                    hit_cnt_o
);

    localparam int CTRL_W = int'(CTRL_SLOT_LSB) + NUM_REGS;
    localparam int PTR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [CTRL_W-1:0]                   ctrl;
    logic [NUM_REGS-1:0][ADDR_WIDTH-1:0] slot_addr;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] slot_data;
    logic [NUM_REGS-1:0]                 slot_en;
    logic                                status_clr;
    logic                                mode_flip;
    logic [HIT_CNT_WIDTH-1:0]            hit_cnt;
    logic [PTR_W-1:0]                    ptr;
    fetch_mode_e                         mode;

    logic                  match_found;
    logic [DATA_WIDTH-1:0] match_data;
    logic                  pg_found;
    logic [DATA_WIDTH-1:0] pg_data;
    logic [PTR_W-1:0]      pg_next;
    logic                  patch_evt;
    logic                  pg_evt;
    logic                  nopg_evt;
    logic                  count_evt;

    code_patch_regs #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .BUS_WIDTH  (SUB_REGS_DATA_WIDTH)
    ) u_regs (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .cyc        (wb_si_cyc_i),
        .stb        (wb_si_stb_i),
        .we         (wb_si_we_i),
        .adr        (wb_si_adr_i),
        .wdata      (wb_si_dat_i),
        .rdata      (wb_si_dat_o),
        .ack        (wb_si_ack_o),
        .hit_cnt    (hit_cnt),
        .ctrl       (ctrl),
        .slot_addr  (slot_addr),
        .slot_data  (slot_data),
        .status_clr (status_clr),
        .mode_flip  (mode_flip)
    );

    assign slot_en = ctrl[CTRL_W-1:CTRL_SLOT_LSB];
    assign mode    = decode_mode(ctrl[CTRL_EN_BIT], ctrl[CTRL_PG_BIT]);

    always_comb begin
        match_found = 1'b0;
        match_data  = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (!match_found && slot_en[k] && (slot_addr[k] == fetch_addr_i)) begin
                match_found = 1'b1;
                match_data  = slot_data[k];
            end
        end
    end

    // First pass takes slots at or above the pointer; second pass wraps to slot 0.
    always_comb begin
        pg_found = 1'b0;
        pg_data  = '0;
        pg_next  = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (!pg_found && slot_en[k] && (PTR_W'(k) >= ptr)) begin
                pg_found = 1'b1;
                pg_data  = slot_data[k];
                pg_next  = (k == NUM_REGS - 1) ? '0 : PTR_W'(k + 1);
            end
        end
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (!pg_found && slot_en[k]) begin
                pg_found = 1'b1;
                pg_data  = slot_data[k];
                pg_next  = (k == NUM_REGS - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    assign patch_evt = (mode == MODE_PATCH) && fetch_valid_i && match_found;
    assign pg_evt    = (mode == MODE_PATTERN) && fetch_valid_i && pg_found;
    assign nopg_evt  = (mode == MODE_PATTERN) && fetch_valid_i && !pg_found;
    assign count_evt = patch_evt | pg_evt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            patch_hit_o  <= 1'b0;
            patch_data_o <= '0;
            pg_valid_o   <= 1'b0;
            nopg_o       <= 1'b0;
        end else begin
            patch_hit_o  <= patch_evt;
            pg_valid_o   <= pg_evt;
            nopg_o       <= nopg_evt;
            patch_data_o <= patch_evt ? match_data : (pg_evt ? pg_data : '0);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ptr <= '0;
        end else if (mode_flip) begin
            ptr <= '0;
        end else if (pg_evt) begin
            ptr <= pg_next;
        end
    end

    // A hit landing on the STATUS read edge survives the clear as a count of one.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            hit_cnt <= '0;
        end else if (status_clr) begin
            hit_cnt <= count_evt ? HIT_CNT_WIDTH'(1) : '0;
        end else if (count_evt && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + HIT_CNT_WIDTH'(1);
        end
    end

    assign hit_cnt_o = hit_cnt;

endmodule

// File: tb/tb_code_patch_unit.sv
// Randomized bench for code_patch_unit against a slot-list reference model,
// plus directed cases for priority, pattern wrap, counter saturation and reset.
module tb_code_patch_unit;

    localparam int AW = 12;
    localparam int DW = 14;
    localparam int NR = 4;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [BW-1:0] wdat, rdat;
    logic          ack;
    logic          fetch_valid;
    logic [AW-1:0] fetch_addr;
    logic          patch_hit;
    logic [DW-1:0] patch_data;
    logic          pg_valid;
    logic          nopg;
    logic [15:0]   hit_cnt;

    code_patch_unit #(
        .ADDR_WIDTH          (AW),
        .DATA_WIDTH          (DW),
        .NUM_REGS            (NR),
        .SUB_REGS_DATA_WIDTH (BW)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wb_si_cyc_i   (cyc),
        .wb_si_stb_i   (stb),
        .wb_si_we_i    (we),
        .wb_si_adr_i   (adr),
        .wb_si_dat_i   (wdat),
        .wb_si_dat_o   (rdat),
        .wb_si_ack_o   (ack),
        .fetch_valid_i (fetch_valid),
        .fetch_addr_i  (fetch_addr),
        .patch_hit_o   (patch_hit),
        .patch_data_o  (patch_data),
        .pg_valid_o    (pg_valid),
        .nopg_o        (nopg),
        .hit_cnt_o     (hit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain slot list, pointer and counter.
    int unsigned m_ctrl, m_ptr, m_cnt;
    int unsigned m_addr[NR];
    int unsigned m_data[NR];
    bit          first_after_reset;
    int unsigned addr_tbl[4] = '{32'h040, 32'h100, 32'h200, 32'h7FF};

    function automatic void model_reset();
        m_ctrl = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        for (int k = 0; k < NR; k++) begin
            m_addr[k] = 0;
            m_data[k] = 0;
        end
    endfunction

    function automatic bit slot_on(input int k);
        return ((m_ctrl >> (2 + k)) & 1) == 1;
    endfunction

    function automatic void model_fetch(input int unsigned a, output bit hit, output bit pgv,
                                        output bit np, output int unsigned d);
        hit = 0; pgv = 0; np = 0; d = 0;
        if ((m_ctrl & 1) == 0) return;
        if (((m_ctrl >> 1) & 1) == 0) begin
            for (int k = 0; k < NR; k++) begin
                if (slot_on(k) && m_addr[k] == a) begin
                    hit = 1; d = m_data[k];
                    break;
                end
            end
        end else begin
            np = 1;
            for (int i = 0; i < NR; i++) begin
                int s;
                s = int'((m_ptr + i) % NR);
                if (slot_on(s)) begin
                    pgv = 1; np = 0; d = m_data[s];
                    m_ptr = (s + 1) % NR;
                    break;
                end
            end
        end
        if (hit || pgv) m_cnt = (m_cnt == 32'hFFFF) ? 32'hFFFF : m_cnt + 1;
    endfunction

    function automatic void model_write(input int unsigned a, input int unsigned d);
        int unsigned nc;
        if (a == 0) begin
            nc = d & ((1 << (2 + NR)) - 1);
            if (((nc ^ m_ctrl) & 2) != 0) m_ptr = 0;
            m_ctrl = nc;
        end else if (a >= 2 && a < 2 + 2 * NR) begin
            if (((a - 2) % 2) == 0) m_addr[(a - 2) / 2] = d & 32'hFFF;
            else                    m_data[(a - 2) / 2] = d & 32'h3FFF;
        end
    endfunction

    function automatic int unsigned model_read(input int unsigned a);
        if (a == 0) return m_ctrl;
        if (a == 1) return m_cnt;
        if (a >= 2 && a < 2 + 2 * NR)
            return (((a - 2) % 2) == 0) ? m_addr[(a - 2) / 2] : m_data[(a - 2) / 2];
        return 0;
    endfunction

    task automatic check_fetch_outputs(input bit h, input bit p, input bit n, input int unsigned d);
        check_eq("patch_hit", patch_hit, h);
        check_eq("patch_data", patch_data, d);
        check_eq("pg_valid", pg_valid, p);
        check_eq("nopg", nopg, n);
        check_eq("hit_cnt", hit_cnt, m_cnt);
    endtask

    // Called at a negedge; drives one fetch cycle and checks the registered response.
    task automatic do_fetch(input int unsigned a, input bit v);
        bit h, p, n;
        int unsigned d;
        h = 0; p = 0; n = 0; d = 0;
        fetch_valid = v;
        fetch_addr  = a[AW-1:0];
        if (v) model_fetch(a, h, p, n, d);
        @(negedge clk);
        check_fetch_outputs(h, p, n, d);
        fetch_valid = 1'b0;
    endtask

    // Called at a negedge; optional fetch placed in the ack cycle.
    task automatic wb_xfer(input bit w, input int unsigned a, input int unsigned d,
                           input bit fon, input int unsigned fa);
        int lat;
        bit got, h, p, n;
        int unsigned fd, exp_rd;
        lat = 0; got = 0; h = 0; p = 0; n = 0; fd = 0;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a[AW-1:0]; wdat = d[BW-1:0];
        fetch_valid = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (ack) got = 1;
        end
        if (!got) begin
            check_eq("ack_timeout", 0, 1);
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
            return;
        end
        if (first_after_reset) check_eq("first_ack_latency_ge2", lat >= 2, 1);
        else                   check_eq("ack_latency", lat, 1);
        first_after_reset = 0;
        if (!w) begin
            exp_rd = model_read(a);
            check_eq("rdata", rdat, exp_rd);
        end
        if (fon) begin
            fetch_valid = 1'b1;
            fetch_addr  = fa[AW-1:0];
            model_fetch(fa, h, p, n, fd);
        end
        if (w) model_write(a, d);
        else if (a == 1) m_cnt = (fon && (h || p)) ? 1 : 0;
        @(negedge clk);
        check_eq("ack_one_cycle", ack, 0);
        if (fon) check_fetch_outputs(h, p, n, fd);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; fetch_valid = 1'b0;
    endtask

    task automatic wb_write(input int unsigned a, input int unsigned d);
        wb_xfer(1, a, d, 0, 0);
    endtask

    task automatic wb_read(input int unsigned a);
        wb_xfer(0, a, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ack"}, ack, 0);
        check_eq({tag, "_rdat"}, rdat, 0);
        check_eq({tag, "_hit"}, patch_hit, 0);
        check_eq({tag, "_data"}, patch_data, 0);
        check_eq({tag, "_pg"}, pg_valid, 0);
        check_eq({tag, "_nopg"}, nopg, 0);
        check_eq({tag, "_cnt"}, hit_cnt, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int unsigned c;
        int lat;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0;
        fetch_valid = 1'b0; fetch_addr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        first_after_reset = 1;

        // Basic patch
        wb_write(2, 32'h100);
        wb_write(3, 32'h2A5);
        wb_write(0, 32'h05);
        do_fetch(32'h100, 1);
        check_eq("basic_patch_data", patch_data, 32'h2A5);
        do_fetch(32'h101, 1);
        wb_read(2);
        wb_read(3);
        wb_write(32'h200, 32'h1234);
        wb_read(32'h200);

        // Lowest slot wins
        wb_write(4, 32'h040); wb_write(5, 32'h111);
        wb_write(8, 32'h040); wb_write(9, 32'h333);
        wb_write(0, 32'h3D);
        do_fetch(32'h040, 1);
        check_eq("priority_data", patch_data, 32'h111);

        // Randomized patch / pattern traffic
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NR; k++) begin
                wb_write(2 + 2 * k, addr_tbl[$urandom_range(0, 3)] | ($urandom_range(0, 1) << 12));
                wb_write(3 + 2 * k, $urandom & 32'hFFFF);
            end
            c = ($urandom_range(0, 15) << 2) | ($urandom_range(0, 7) != 0 ? 1 : 0)
                | ($urandom_range(0, 1) << 1);
            wb_write(0, c);
            repeat (12) do_fetch(addr_tbl[$urandom_range(0, 3)], $urandom_range(0, 3) != 0);
            wb_read($urandom_range(0, 2 + 2 * NR));
        end

        // Pattern generator
        for (int k = 0; k < NR; k++) wb_write(3 + 2 * k, 32'h0A0 + 32'h11 * k);
        wb_write(0, 32'h01);
        wb_write(0, 32'h17);
        do_fetch(0, 1); check_eq("pg_first", patch_data, 32'h0A0);
        do_fetch(0, 1); check_eq("pg_second", patch_data, 32'h0C2);
        do_fetch(0, 1); check_eq("pg_wrap", patch_data, 32'h0A0);
        wb_write(0, 32'h03);
        do_fetch(0, 1); check_eq("nopg_pulse", nopg, 1);
        do_fetch(0, 0);
        wb_write(0, 32'h17);
        do_fetch(0, 1);
        wb_write(0, 32'h15);
        wb_write(0, 32'h17);
        do_fetch(0, 1);

        // Disabled unit
        wb_write(0, 32'h3C);
        do_fetch(32'h040, 1);
        wb_write(0, 32'h3E);
        do_fetch(32'h040, 1);

        // CTRL write coinciding with a fetch uses the old enables
        wb_write(2, 32'h100);
        wb_write(0, 32'h05);
        wb_xfer(1, 0, 32'h01, 1, 32'h100);
        do_fetch(32'h100, 1);
        wb_read(0);

        // Counter saturation and read-clear
        wb_write(0, 32'h05);
        wb_read(1);
        fetch_valid = 1'b1;
        fetch_addr  = 12'h100;
        for (int i = 0; i < 32'hFFFE; i++) begin
            bit h, p, n;
            int unsigned d;
            model_fetch(32'h100, h, p, n, d);
            @(negedge clk);
        end
        fetch_valid = 1'b0;
        check_eq("cnt_preload", hit_cnt, 32'hFFFE);
        repeat (3) do_fetch(32'h100, 1);
        check_eq("cnt_saturated", hit_cnt, 32'hFFFF);
        wb_read(1);
        wb_read(1);
        wb_xfer(0, 1, 0, 1, 32'h100);
        check_eq("cnt_after_clear_hit", hit_cnt, 1);
        wb_read(1);

        // Reset during a held write strobe
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 12'h006; wdat = 16'h0ABC;
        fetch_valid = 1'b1; fetch_addr = 12'h100;
        lat = 0;
        while (!ack && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("pre_reset_ack", ack, 1);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        fetch_valid = 1'b0;
        repeat (2) @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        rst = 1'b0;
        model_reset();
        first_after_reset = 1;
        wb_read(6);
        wb_read(0);
        do_fetch(32'h100, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
